// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchroniser, mid-bit sampling FSM and
// a small show-ahead FIFO presented as a valid/ready byte stream.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_err,
  output logic               overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]    T_HALF    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]    T_FULL    = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CNT_DEPTH = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [TW-1:0]       timer, timer_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [7:0]          shift, shift_n;
  logic                rx_meta, rx_s, rx_prev;
  logic                push, ferr;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                full, pop, accept;

  // NOTE: every register is updated with <= so all flops sample the values
  // from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      frame_err <= ferr;
      overflow  <= push && !accept;
    end
  end

  // NOTE: each output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    timer_n   = timer + TW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    ferr      = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        // Only a fresh falling edge arms a frame, so a held-low break line
        // cannot retrigger after a framing error.
        if (rx_prev && !rx_s) state_n = START;
      end
      START: begin
        if (timer == T_HALF) begin
          timer_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == T_FULL) begin
          timer_n   = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (timer == T_FULL) begin
          timer_n = '0;
          push    = rx_s;
          ferr    = !rx_s;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign full     = (count == CNT_DEPTH);
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign accept   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the head byte is masked while empty, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shift;
  end

  assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes are queued as they are sent and
// compared when the stream hands them over; flag pulses are counted.
module tb_uart_rx_fifo;

  localparam int CPB = 8;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW:0]   fifo_count;
  logic          frame_err, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ferr_cnt = 0, ovf_cnt = 0, valid_cycles = 0, rise_cyc = -1;
  logic valid_d = 1'b0;
  logic [7:0] sb_q[$];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  // Monitor: pops scoreboard on every handshake, counts flag pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) check("unexpected_pop", 32'(rx_data), 32'hFFFF_FFFF);
        else check("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
      end
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
      if (frame_err && overflow) check("flags_together", 1, 0);
      if (rx_valid) valid_cycles++;
      if (rx_valid && !valid_d) rise_cyc = cyc;
    end
    valid_d = rx_valid;
  end

  initial begin
    int t0, f0, o0, v0;
    tick(3);
    rst = 1'b0;
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data",  32'(rx_data), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ferr",  32'(frame_err), 0);
    check("rst_ovf",   32'(overflow), 0);
    tick(5);

    // Single byte with consumer ready: 3 cycles sync/edge, CPB/2 start,
    // 8*CPB data, CPB stop -> visible 79 cycles after the start edge.
    rx_ready = 1'b1;
    f0 = ferr_cnt; o0 = ovf_cnt; v0 = valid_cycles;
    t0 = cyc;
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(10);
    check("a5_latency", 32'(rise_cyc - t0), 32'(3 + CPB/2 + 9*CPB));
    check("a5_valid_len", 32'(valid_cycles - v0), 1);
    check("a5_ferr", 32'(ferr_cnt - f0), 0);
    check("a5_ovf",  32'(ovf_cnt - o0), 0);

    // Short low glitch: rejected at start-bit mid sample.
    f0 = ferr_cnt;
    rx = 1'b0; tick(3); rx = 1'b1;
    tick(30);
    check("glitch_count", 32'(fifo_count), 0);
    check("glitch_ferr",  32'(ferr_cnt - f0), 0);

    // Framing error followed by a held-low break.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(20);
    check("break_ferr",  32'(ferr_cnt - f0), 1);
    check("break_count", 32'(fifo_count), 0);

    // Overflow: fifth byte dropped while consumer stalls.
    rx_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    tick(10);
    check("ovf_count", 32'(fifo_count), 4);
    check("ovf_pulse", 32'(ovf_cnt - o0), 1);
    rx_ready = 1'b1;
    tick(10);
    check("drain_count", 32'(fifo_count), 0);
    check("drain_sb", 32'(sb_q.size()), 0);

    // Full FIFO with pop coinciding with the fifth push.
    rx_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'h11 + 8'(i));
      send_frame(8'h11 + 8'(i), 1'b1);
    end
    tick(4);
    check("full_count", 32'(fifo_count), 4);
    sb_q.push_back(8'h15);
    fork
      send_frame(8'h15, 1'b1);
      begin
        tick(3 + CPB/2 + 9*CPB - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("pushpop_count", 32'(fifo_count), 4);
      end
    join
    tick(5);
    check("pushpop_ovf", 32'(ovf_cnt - o0), 0);
    rx_ready = 1'b1;
    tick(10);
    check("wrap_count", 32'(fifo_count), 0);
    check("wrap_sb", 32'(sb_q.size()), 0);

    // Reset during data bit 6 of 0x81 with two bytes buffered.
    rx_ready = 1'b0;
    sb_q.push_back(8'h21); send_frame(8'h21, 1'b1);
    sb_q.push_back(8'h22); send_frame(8'h22, 1'b1);
    tick(4);
    check("pre_rst_count", 32'(fifo_count), 2);
    f0 = ferr_cnt; o0 = ovf_cnt;
    fork
      send_frame(8'h81, 1'b1);
      begin
        tick(7*CPB + 4);
        rst = 1'b1;
        sb_q.delete();
        tick(1);
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_data",  32'(rx_data), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_flags", 32'({frame_err, overflow}), 0);
        rst = 1'b0;
      end
    join
    tick(30);
    check("post_rst_count", 32'(fifo_count), 0);
    check("post_rst_flags", 32'(ferr_cnt - f0 + ovf_cnt - o0), 0);
    rx_ready = 1'b1;
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    tick(10);
    check("final_sb", 32'(sb_q.size()), 0);
    check("final_count", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
